// File: rtl/ls_agu.sv
// rtl/ls_agu.sv - load/store address generation unit with an in-order issue queue
package ls_agu_pkg;
   typedef logic [3:0] LS_FUNC;

   localparam LS_FUNC LS_NONE = 4'd0;
   localparam LS_FUNC LS_LB   = 4'd1;
   localparam LS_FUNC LS_LH   = 4'd2;
   localparam LS_FUNC LS_LW   = 4'd3;
   localparam LS_FUNC LS_LBU  = 4'd4;
   localparam LS_FUNC LS_LHU  = 4'd5;
   localparam LS_FUNC LS_SB   = 4'd6;
   localparam LS_FUNC LS_SH   = 4'd7;
   localparam LS_FUNC LS_SW   = 4'd8;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      LS_FUNC      ls_func;
      logic [6:0]  rd;
   } INSTRUCTION_LS;
endpackage

module ls_agu
   import ls_agu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  LS_FUNC        in_ls_func,
   input  logic [31:0]   in_base,
   input  logic [11:0]   in_imm,
   input  logic [31:0]   in_data,
   input  logic [6:0]    in_rd,
   input  logic          flush,
   output INSTRUCTION_LS instruction,
   input  logic          instruction_ready,
   output logic          misaligned_valid,
   output logic [6:0]    misaligned_rd,
   output logic [31:0]   misaligned_addr
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;

   logic [31:0]   r_q_addr [DEPTH];
   logic [31:0]   r_q_data [DEPTH];
   LS_FUNC        r_q_func [DEPTH];
   logic [6:0]    r_q_rd   [DEPTH];

   logic          r_mis_valid;
   logic [6:0]    r_mis_rd;
   logic [31:0]   r_mis_addr;

   logic          w_full;
   logic          w_empty;
   logic          w_accept;
   logic [31:0]   w_addr;
   logic          w_mem_op;
   logic          w_misaligned;
   logic          w_push;
   logic          w_pop;
   logic          w_mis_hit;

   assign w_full   = (r_count == C_FULL);
   assign w_empty  = (r_count == '0);
   assign in_ready = !w_full;

   // Accepts and issues are both frozen while reset or flush is applied.
   assign w_accept = in_valid && in_ready && !flush && reset;
   assign w_addr   = in_base + {{20{in_imm[11]}}, in_imm};
   assign w_mem_op = (in_ls_func >= LS_LB) && (in_ls_func <= LS_SW);

   always_comb begin
      w_misaligned = 1'b0;
      case (in_ls_func)
         LS_LH, LS_LHU, LS_SH: w_misaligned = w_addr[0];
         LS_LW, LS_SW:         w_misaligned = (w_addr[1:0] != 2'b00);
         default:              w_misaligned = 1'b0;
      endcase
   end

   assign w_push    = w_accept && w_mem_op && !w_misaligned;
   assign w_mis_hit = w_accept && w_mem_op && w_misaligned;
   assign w_pop     = !w_empty && instruction_ready && !flush && reset;

   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage needs no reset; the output mux never exposes an empty queue.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_addr[r_wr_ptr] <= w_addr;
         r_q_data[r_wr_ptr] <= in_data;
         r_q_func[r_wr_ptr] <= in_ls_func;
         r_q_rd[r_wr_ptr]   <= in_rd;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_mis_valid <= 1'b0;
         r_mis_rd    <= '0;
         r_mis_addr  <= '0;
      end else begin
         r_mis_valid <= w_mis_hit;
         if (w_mis_hit) begin
            r_mis_rd   <= in_rd;
            r_mis_addr <= w_addr;
         end
      end
   end

   assign misaligned_valid = r_mis_valid;
   assign misaligned_rd    = r_mis_rd;
   assign misaligned_addr  = r_mis_addr;

   always_comb begin
      instruction = '0;
      if (w_pop) begin
         instruction.addr    = r_q_addr[r_rd_ptr];
         instruction.data    = r_q_data[r_rd_ptr];
         instruction.ls_func = r_q_func[r_rd_ptr];
         instruction.rd      = r_q_rd[r_rd_ptr];
      end
   end
endmodule

// File: tb/tb_ls_agu.sv
// tb/tb_ls_agu.sv - scoreboard bench for ls_agu with a queue-based reference model
module tb_ls_agu;
   import ls_agu_pkg::*;

   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   LS_FUNC        in_ls_func;
   logic [31:0]   in_base;
   logic [11:0]   in_imm;
   logic [31:0]   in_data;
   logic [6:0]    in_rd;
   logic          flush;
   INSTRUCTION_LS instruction;
   logic          instruction_ready;
   logic          misaligned_valid;
   logic [6:0]    misaligned_rd;
   logic [31:0]   misaligned_addr;

   always #5 clk = ~clk;

   ls_agu #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_ls_func(in_ls_func), .in_base(in_base), .in_imm(in_imm), .in_data(in_data),
      .in_rd(in_rd), .flush(flush), .instruction(instruction),
      .instruction_ready(instruction_ready), .misaligned_valid(misaligned_valid),
      .misaligned_rd(misaligned_rd), .misaligned_addr(misaligned_addr)
   );

   typedef struct {
      INSTRUCTION_LS ins;
      int            cyc;
   } exp_t;

   INSTRUCTION_LS model_q[$];
   exp_t          iss_q[$];
   exp_t          mis_q[$];
   int            cyc = 0;
   int            tests = 0;
   int            fails = 0;
   logic          exp_ready = 1'b1;
   bit            chk_en = 1'b0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic bit is_mem(LS_FUNC f);
      return (f == LS_LB) || (f == LS_LH) || (f == LS_LW) || (f == LS_LBU) ||
             (f == LS_LHU) || (f == LS_SB) || (f == LS_SH) || (f == LS_SW);
   endfunction

   function automatic bit is_misaligned(LS_FUNC f, logic [31:0] a);
      if (f == LS_LH || f == LS_LHU || f == LS_SH) return (a % 2) != 0;
      if (f == LS_LW || f == LS_SW) return (a % 4) != 0;
      return 1'b0;
   endfunction

   task automatic step(bit rst, bit v, LS_FUNC f, logic [31:0] b, logic [11:0] imm,
                       logic [31:0] d, logic [6:0] rd, bit rdy, bit fl);
      INSTRUCTION_LS op;
      exp_t          e;
      bit            room;
      @(posedge clk);
      #1;
      cyc++;
      reset = !rst; in_valid = v; in_ls_func = f; in_base = b; in_imm = imm;
      in_data = d; in_rd = rd; instruction_ready = rdy; flush = fl;
      room = model_q.size() < DEPTH;
      exp_ready = room;
      if (rst || fl) begin
         model_q.delete();
      end else begin
         if (model_q.size() > 0 && rdy) begin
            e.ins = model_q.pop_front();
            e.cyc = cyc;
            iss_q.push_back(e);
         end
         if (v && room) begin
            op.addr    = b + 32'($signed(imm));
            op.data    = d;
            op.ls_func = f;
            op.rd      = rd;
            if (is_mem(f)) begin
               if (is_misaligned(f, op.addr)) begin
                  e.ins = op;
                  e.cyc = cyc + 1;
                  mis_q.push_back(e);
               end else begin
                  model_q.push_back(op);
               end
            end
         end
      end
   endtask

   task automatic idle(bit rdy);
      step(1'b0, 1'b0, LS_NONE, 32'h0, 12'h0, 32'h0, 7'h0, rdy, 1'b0);
   endtask

   task automatic op(LS_FUNC f, logic [31:0] b, logic [11:0] imm, logic [6:0] rd, bit rdy);
      step(1'b0, 1'b1, f, b, imm, $urandom, rd, rdy, 1'b0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (chk_en) begin
         chk("in_ready", 32'(in_ready), 32'(exp_ready));
         if (instruction.ls_func != LS_NONE) begin
            if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
               e = iss_q.pop_front();
               chk("issue_func", 32'(instruction.ls_func), 32'(e.ins.ls_func));
               chk("issue_addr", instruction.addr, e.ins.addr);
               chk("issue_data", instruction.data, e.ins.data);
               chk("issue_rd", 32'(instruction.rd), 32'(e.ins.rd));
            end else begin
               tests++; fails++;
               $display("FAIL unexpected_issue: got func %0d addr %h expected LS_NONE (cycle %0d)",
                        instruction.ls_func, instruction.addr, cyc);
            end
         end else begin
            chk("idle_addr", instruction.addr, 32'h0);
            chk("idle_data", instruction.data, 32'h0);
            chk("idle_rd", 32'(instruction.rd), 32'h0);
            if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
               e = iss_q.pop_front();
               tests++; fails++;
               $display("FAIL missing_issue: got LS_NONE expected func %0d addr %h (cycle %0d)",
                        e.ins.ls_func, e.ins.addr, cyc);
            end
         end
         if (misaligned_valid) begin
            if (mis_q.size() > 0 && mis_q[0].cyc == cyc) begin
               e = mis_q.pop_front();
               chk("mis_rd", 32'(misaligned_rd), 32'(e.ins.rd));
               chk("mis_addr", misaligned_addr, e.ins.addr);
            end else begin
               tests++; fails++;
               $display("FAIL unexpected_misaligned: got valid 1 expected 0 (cycle %0d)", cyc);
            end
         end else if (mis_q.size() > 0 && mis_q[0].cyc == cyc) begin
            e = mis_q.pop_front();
            tests++; fails++;
            $display("FAIL missing_misaligned: got valid 0 expected 1 addr %h (cycle %0d)",
                     e.ins.addr, cyc);
         end
      end
   end

   initial begin
      reset = 1'b0; in_valid = 1'b0; in_ls_func = LS_NONE; in_base = '0; in_imm = '0;
      in_data = '0; in_rd = '0; flush = 1'b0; instruction_ready = 1'b0;

      step(1'b1, 1'b0, LS_NONE, 32'h0, 12'h0, 32'h0, 7'h0, 1'b1, 1'b0);
      chk_en = 1'b1;
      step(1'b1, 1'b0, LS_NONE, 32'h0, 12'h0, 32'h0, 7'h0, 1'b1, 1'b0);
      chk("rst_mis_valid", 32'(misaligned_valid), 32'h0);
      chk("rst_mis_rd", 32'(misaligned_rd), 32'h0);
      chk("rst_mis_addr", misaligned_addr, 32'h0);

      // single op, negative offset
      op(LS_LW, 32'h1000, 12'hFFC, 7'd5, 1'b1);
      repeat (3) idle(1'b1);

      // fill to full, one rejected offer, then drain
      for (int i = 0; i < 4; i++) op(LS_SW, 32'h3000, 12'(i * 4), 7'(10 + i), 1'b0);
      op(LS_SW, 32'h3100, 12'h0, 7'd14, 1'b0);
      repeat (5) idle(1'b1);

      // misaligned half then aligned half
      op(LS_SH, 32'h2001, 12'h0, 7'd20, 1'b1);
      op(LS_LH, 32'h2002, 12'h0, 7'd21, 1'b1);
      repeat (2) idle(1'b1);

      // address wrap
      op(LS_LW, 32'hFFFF_FFFC, 12'd8, 7'd22, 1'b1);
      repeat (2) idle(1'b1);

      // flush with a simultaneous offer
      for (int i = 0; i < 3; i++) op(LS_LBU, 32'h4000 + 32'(i), 12'h0, 7'(30 + i), 1'b0);
      step(1'b0, 1'b1, LS_LW, 32'h4100, 12'h0, 32'h55, 7'd33, 1'b1, 1'b1);
      repeat (3) idle(1'b1);

      // ready toggling
      for (int i = 0; i < 3; i++) op(LS_SB, 32'h5000 + 32'(i), 12'h0, 7'(40 + i), 1'b0);
      for (int i = 0; i < 8; i++) idle(i % 2 == 0);

      // non-memory codes are dropped silently
      op(4'd12, 32'h6000, 12'h0, 7'd50, 1'b1);
      op(4'd15, 32'h6001, 12'h0, 7'd51, 1'b1);
      repeat (2) idle(1'b1);

      // reset mid-operation
      op(LS_LW, 32'h7000, 12'h0, 7'd60, 1'b0);
      op(LS_SW, 32'h7004, 12'h0, 7'd61, 1'b0);
      step(1'b1, 1'b0, LS_NONE, 32'h0, 12'h0, 32'h0, 7'h0, 1'b1, 1'b0);
      repeat (3) idle(1'b1);

      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
              LS_FUNC'($urandom_range(0, 9)), {$urandom_range(0, 255), 8'h0} | 32'($urandom_range(0, 7)),
              12'($urandom), $urandom, 7'($urandom), $urandom_range(0, 2) != 0,
              $urandom_range(0, 39) == 0);
      end

      repeat (8) idle(1'b1);
      chk("drain_model_q", model_q.size(), 32'h0);
      chk("drain_issue_q", iss_q.size(), 32'h0);
      chk("drain_mis_q", mis_q.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ls_agu.md
LS_AGU -- requirements
Module: ls_agu

Interface
REQ-001 Parameter: DEPTH, 4, queue entries; power of two, minimum 2.
REQ-002 Clocking SHALL be: one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  upstream offers an LS op.
REQ-006 in_ready  output  1  block accepts the op this cycle.
REQ-007 in_ls_func  input  LS_FUNC  memory op code.
REQ-008 in_base  input  32  rs1 value.
REQ-009 in_imm  input  12  signed offset.
REQ-010 in_data  input  32  store data (rs2).
REQ-011 in_rd  input  7  destination tag.
REQ-012 flush  input  1  discard all queued ops.
REQ-013 instruction  output  INSTRUCTION_LS  op to the downstream LS pipe (fields addr, data, ls_func, rd).
REQ-014 instruction_ready  input  1  downstream LS pipe consumes instruction this cycle.
REQ-015 misaligned_valid  output  1  one-cycle pulse: an op was rejected as misaligned.
REQ-016 misaligned_rd  output  7  tag of the rejected op.
REQ-017 misaligned_addr  output  32  computed address of the rejected op.

Function
REQ-018 Effective address SHALL be in_base + sign-extended in_imm, modulo 2^32, computed at accept time and stored in the queue.
REQ-019 Accept SHALL occur when in_valid && in_ready; in_ready SHALL equal !full from registered state, with no combinational path from instruction_ready.
REQ-020 Accepted ops SHALL be queued in order, at most DEPTH entries, with wrap-around read/write pointers and an occupancy counter of width log2(DEPTH)+1.
REQ-021 Misaligned ops SHALL never be enqueued: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
REQ-022 A misaligned op SHALL raise misaligned_valid on the cycle after accept for exactly one cycle, with misaligned_rd and misaligned_addr.
REQ-023 An op whose in_ls_func is not one of the eight memory codes SHALL be accepted and dropped with no queue entry and no misaligned pulse.
REQ-024 Issue SHALL occur combinationally when the queue is non-empty and instruction_ready=1; instruction then carries the head entry, and the head SHALL pop on that clock edge.
REQ-025 In every non-issue cycle instruction.ls_func SHALL be LS_NONE, and addr, data and rd SHALL be 0, because the downstream pipe samples every cycle.
REQ-026 Each op SHALL be presented with a memory ls_func in exactly one cycle, which prevents double stores.
REQ-027 Minimum latency from accept to issue SHALL be 1 cycle (empty queue, instruction_ready=1).
REQ-028 Simultaneous accept and issue SHALL leave occupancy unchanged; the full flag SHALL drop one cycle after a pop on a full queue.
REQ-029 flush=1 SHALL empty the queue at the clock edge, suppress issue in that cycle (instruction is LS_NONE), ignore any accept in that cycle, and cancel any pending misaligned pulse.
REQ-030 Store data SHALL pass through unshifted; byte-lane alignment is the downstream stage's job.

Reset
REQ-031 With reset=0 at a rising edge: pointers and count become 0, in_ready is 1 on the next cycle, misaligned_valid, misaligned_rd and misaligned_addr become 0, and instruction is LS_NONE with zero fields.
REQ-032 Reset mid-operation SHALL discard all queued ops; no op accepted before reset is issued afterwards.
REQ-033 Queue storage contents are don't-care after reset and SHALL never be visible on instruction while the queue is empty.

Verification
REQ-034 Single op: LW with base=0x1000, imm=-4, instruction_ready=1 -> next cycle instruction.addr=0x0FFC, ls_func=LW, one cycle only, then LS_NONE.
REQ-035 Fill: 4 SW ops with instruction_ready=0 -> in_ready=0 after the 4th; raise ready for 4 cycles -> 4 ops issued in order with no gaps, and in_ready returns to 1.
REQ-036 Misaligned: SH at base=0x2001, imm=0 -> misaligned_valid=1 for one cycle with addr 0x2001, no issue; LH at 0x2002 issues normally.
REQ-037 Wrap: base=0xFFFFFFFC, imm=8 -> addr=0x00000004.
REQ-038 Flush: 3 ops queued, flush=1 together with in_valid=1 -> queue empty, nothing issued later, in_ready=1.
REQ-039 Ready toggling: instruction_ready alternating 1/0 with 3 ops queued -> each op issued exactly once, and LS_NONE in every ready=0 cycle.
